// File: rtl/uart_alu_top.sv
// uart_alu_top: FPGA top of the UART ALU. Receives framed command packets on
// a 8N1 serial line and answers on a second serial line with either an echo
// of the payload or a 32-bit add/multiply result.
//   clk  - core clock
//   rst  - asynchronous reset, active low
//   rx_i - UART serial in (idle high)
//   tx_o - UART serial out (idle high)
// Packet: opcode, reserved, LEN lo, LEN hi, payload[LEN-4]; LEN < 4 acts as 4.
`timescale 1ns/1ps
module uart_alu_top #(
  parameter int CLK_FREQ_HZ = 32_258_065,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);
  localparam int PRESCALE = CLK_FREQ_HZ / (BAUD_RATE * 8);
  localparam int BIT_CYC  = PRESCALE * 8;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);
  localparam logic [AW:0] DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  OP_ECHO = 8'hEC, OP_ADD = 8'hAD, OP_MUL = 8'h88;

  // ---------------- UART receiver ----------------
  logic [1:0]  rx_sync_q;
  logic        rx_busy_q, rx_vld_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  // Bit 0 is the start bit sampled mid-bit, 1..8 data, 9 stop. A low stop
  // bit is a framing error: the byte is dropped silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q <= 2'b11; rx_busy_q <= 1'b0; rx_vld_q <= 1'b0;
      rx_cnt_q  <= '0;    rx_bit_q  <= '0;   rx_sh_q  <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_i};
      rx_vld_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_sync_q[1]) begin
          rx_busy_q <= 1'b1; rx_cnt_q <= HALF_LAST; rx_bit_q <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= BIT_LAST;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q[1]) rx_busy_q <= 1'b0;   // start glitch
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_vld_q  <= rx_sync_q[1];
        end else begin
          rx_sh_q <= {rx_sync_q[1], rx_sh_q[7:1]};
        end
      end
    end
  end

  // One-byte holding slot: a byte arriving while the parser is busy in
  // COMPUTE or RESULT waits here, so nothing is lost across states.
  logic       pend_v_q, take;
  logic [7:0] pend_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v_q <= 1'b0; pend_q <= '0;
    end else if (rx_vld_q) begin
      pend_v_q <= 1'b1; pend_q <= rx_sh_q;
    end else if (take) begin
      pend_v_q <= 1'b0;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_f_q, free;
  logic          push1, push4, pop;
  logic [31:0]   acc_q, acc_d;

  assign free = DEPTH - cnt_f_q;

  always_ff @(posedge clk) begin
    if (push1) mem[wp_q] <= pend_q;
    if (push4) for (int k = 0; k < 4; k++) mem[wp_q + AW'(k)] <= acc_q[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0; rp_q <= '0; cnt_f_q <= '0;
    end else begin
      wp_q    <= wp_q + (push4 ? AW'(4) : AW'(push1));
      rp_q    <= rp_q + AW'(pop);
      cnt_f_q <= cnt_f_q + (push4 ? (AW+1)'(4) : (AW+1)'(push1)) - (AW+1)'(pop);
    end
  end

  // ---------------- UART transmitter ----------------
  logic        tx_busy_q, tx_q, tx_free;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;

  // Free in the last cycle of the stop bit so frames run back to back.
  assign tx_free = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == '0);
  assign pop     = tx_free && (cnt_f_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy_q <= 1'b0; tx_q <= 1'b1; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '1;
    end else if (pop) begin
      tx_busy_q <= 1'b1; tx_q <= 1'b0;            // start bit
      tx_sh_q   <= {1'b1, mem[rp_q]};             // data then stop
      tx_bit_q  <= '0;   tx_cnt_q <= BIT_LAST;
    end else if (tx_free) begin
      tx_busy_q <= 1'b0;
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 16'd1;
    end else begin
      tx_q     <= tx_sh_q[0];
      tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
      tx_bit_q <= tx_bit_q + 4'd1;
      tx_cnt_q <= BIT_LAST;
    end
  end
  assign tx_o = tx_q;

  // ---------------- Packet parser ----------------
  typedef enum logic [2:0] {S_HDR, S_ECHO, S_ARITH, S_COMPUTE, S_DRAIN, S_RESULT} state_e;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, len_q, len_d, len_new;
  logic [7:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d, mcnd_q, mcnd_d, mplr_q, mplr_d, word;
  logic [4:0]  mcnt_q, mcnt_d;
  logic        have_q, have_d, fin_q, fin_d, last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR; cnt_q <= '0; len_q <= '0; op_q <= '0; acc_q <= '0;
      opnd_q <= '0; mcnd_q <= '0; mplr_q <= '0; mcnt_q <= '0; have_q <= 1'b0; fin_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; len_q <= len_d; op_q <= op_d; acc_q <= acc_d;
      opnd_q <= opnd_d; mcnd_q <= mcnd_d; mplr_q <= mplr_d; mcnt_q <= mcnt_d;
      have_q <= have_d; fin_q <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; len_d = len_q; op_d = op_q; acc_d = acc_q;
    opnd_d = opnd_q; mcnd_d = mcnd_q; mplr_d = mplr_q; mcnt_d = mcnt_q;
    have_d = have_q; fin_d = fin_q;
    take = 1'b0; push1 = 1'b0; push4 = 1'b0;
    last    = (cnt_q + 16'd1 == len_q);
    word    = {pend_q, opnd_q[31:8]};            // LE operand assembly
    len_new = {pend_q, len_q[7:0]};
    case (state_q)
      S_HDR: if (pend_v_q) begin
        take  = 1'b1;
        cnt_d = cnt_q + 16'd1;
        case (cnt_q[1:0])
          2'd0: begin op_d = pend_q; acc_d = '0; have_d = 1'b0; end
          2'd2: len_d = {8'h00, pend_q};
          2'd3: begin
            len_d = len_new;
            cnt_d = 16'd4;
            if (op_q == OP_ECHO)                         state_d = S_ECHO;
            else if (op_q == OP_ADD || op_q == OP_MUL)   state_d = S_ARITH;
            else                                         state_d = S_DRAIN;
            if (len_new <= 16'd4) begin                  // no payload
              cnt_d   = '0;
              state_d = (state_d == S_ARITH) ? S_RESULT : S_HDR;
            end
          end
          default: ;
        endcase
      end
      S_ECHO, S_DRAIN: if (pend_v_q) begin
        take  = 1'b1;
        cnt_d = cnt_q + 16'd1;
        push1 = (state_q == S_ECHO) && (cnt_f_q != DEPTH);  // drop on full
        if (last) begin state_d = S_HDR; cnt_d = '0; end
      end
      S_ARITH: if (pend_v_q) begin
        take   = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        opnd_d = word;
        if (cnt_q[1:0] == 2'd3) begin                // payload starts at 4
          have_d = 1'b1;
          if (!have_q)              acc_d = word;
          else if (op_q == OP_ADD)  acc_d = acc_q + word;
          else begin
            mcnd_d = acc_q; mplr_d = word; acc_d = '0; mcnt_d = '0;
            fin_d  = last;  state_d = S_COMPUTE;
          end
        end
        if (last && state_d == S_ARITH) state_d = S_RESULT;
      end
      S_COMPUTE: begin                               // one shift-add per cycle
        if (mplr_q[0]) acc_d = acc_q + mcnd_q;
        mcnd_d = mcnd_q << 1;
        mplr_d = mplr_q >> 1;
        mcnt_d = mcnt_q + 5'd1;
        if (mcnt_q == 5'd31) state_d = fin_q ? S_RESULT : S_ARITH;
      end
      S_RESULT: if (free >= (AW+1)'(4)) begin
        push4   = 1'b1;
        state_d = S_HDR;
        cnt_d   = '0;
      end
      default: state_d = S_HDR;
    endcase
  end
endmodule

// File: tb/tb_uart_alu_top.sv
`timescale 1ns/1ps
module tb_uart_alu_top;
  localparam int BIT = 16;   // 8 * prescale(2) cycles per bit

  logic clk = 1'b0, rst = 1'b1, rx_i = 1'b1;
  logic tx_o;
  always #5 clk = ~clk;

  uart_alu_top #(.CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .tx_o(tx_o));

  typedef struct packed {
    logic [159:0] din;  logic [7:0] nin;
    logic [63:0]  dexp; logic [7:0] nexp;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic [7:0] got[$];

  // Serial decoder on tx_o.
  initial begin : mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && tx_o === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (BIT) @(negedge clk); b[i] = tx_o; end
        repeat (BIT) @(negedge clk);
        got.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected finish", 0);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b);   // start + data; line left high
    rx_i = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx_i = b[i]; repeat (BIT) @(negedge clk); end
    rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b); repeat (BIT) @(negedge clk);
  endtask

  // Bytes written left to right in a concatenation, first byte leftmost.
  task automatic send_pk(input logic [159:0] d, input int n);
    for (int i = 0; i < n; i++) send_byte(d[(n-1-i)*8 +: 8]);
  endtask

  task automatic expect_seq(input string nm, input logic [7:0] exp[$]);
    int n;
    logic [7:0] a;
    n = exp.size();
    for (int c = 0; c < 200*n + 600 && got.size() < n; c++) @(negedge clk);
    repeat (250) @(negedge clk);   // catch any extra byte
    chk({nm, " count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = (got.size() > 0) ? got.pop_front() : 8'hxx;
      chk($sformatf("%s byte%0d", nm, i), {24'd0, a}, {24'd0, exp[i]});
    end
    got.delete();
  endtask

  task automatic expect_pk(input string nm, input logic [63:0] e, input int n);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(e[(n-1-i)*8 +: 8]);
    expect_seq(nm, q);
  endtask

  // Measure cycles from mid stop bit of the last byte to the first TX start bit.
  task automatic send_last_timed(input logic [7:0] b, output int lat);
    send_bits(b);
    repeat (BIT/2) @(negedge clk);
    lat = 0;
    while (tx_o !== 1'b0 && lat < 200) begin @(negedge clk); lat++; end
  endtask

  // Random packets against a byte-stream model of the protocol.
  task automatic run_random(input int npkt);
    logic [7:0] sq[$], eq[$], pay[$];
    logic [7:0] op; logic [31:0] acc, w; logic [15:0] len; int r, pl;
    for (int p = 0; p < npkt; p++) begin
      r  = $urandom_range(0, 3);
      pl = $urandom_range(0, 10);
      case (r)
        0: op = 8'hEC;
        1: op = 8'hAD;
        2: op = 8'h88;
        default: op = 8'h10 + 8'($urandom_range(0, 15));
      endcase
      len = (pl == 0) ? 16'($urandom_range(0, 4)) : 16'(pl + 4);
      pay.delete();
      for (int i = 0; i < pl; i++) pay.push_back(8'($urandom));
      sq.push_back(op); sq.push_back(8'($urandom)); sq.push_back(len[7:0]); sq.push_back(len[15:8]);
      foreach (pay[i]) sq.push_back(pay[i]);
      if (op == 8'hEC) begin
        foreach (pay[i]) eq.push_back(pay[i]);
      end else if (op == 8'hAD || op == 8'h88) begin
        acc = 0;
        for (int k = 0; k < pl/4; k++) begin
          w = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
          if (k == 0) acc = w; else if (op == 8'hAD) acc = acc + w; else acc = acc * w;
        end
        for (int k = 0; k < 4; k++) eq.push_back(acc[8*k +: 8]);
      end
    end
    foreach (sq[i]) send_byte(sq[i]);
    expect_seq("random", eq);
  endtask

  initial begin : main
    vec_t vt[9];
    int lat;
    vt[0] = {160'({8'hEC,8'h00,8'h07,8'h00,8'h41,8'h42,8'h43}), 8'd7, 64'({8'h41,8'h42,8'h43}), 8'd3};
    vt[1] = {160'({8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h00,8'h00,8'h00,8'h02,8'h00,8'h00,8'h00}), 8'd12,
             64'({8'h03,8'h00,8'h00,8'h00}), 8'd4};
    vt[2] = {160'({8'hAD,8'h00,8'h0C,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'h02,8'h00,8'h00,8'h00}), 8'd12,
             64'({8'h01,8'h00,8'h00,8'h00}), 8'd4};
    vt[3] = {160'({8'hAD,8'h00,8'h04,8'h00}), 8'd4, 64'({8'h00,8'h00,8'h00,8'h00}), 8'd4};
    vt[4] = {160'({8'h88,8'h00,8'h10,8'h00,8'h03,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00,
                   8'h02,8'h00,8'h00,8'h00}), 8'd16, 64'({8'h1E,8'h00,8'h00,8'h00}), 8'd4};
    vt[5] = {160'({8'h55,8'h00,8'h06,8'h00,8'hAA,8'hBB,8'hEC,8'h00,8'h05,8'h00,8'h5A}), 8'd11,
             64'({8'h5A}), 8'd1};
    vt[6] = {160'({8'hAD,8'h00,8'h0A,8'h00,8'h05,8'h00,8'h00,8'h00,8'h07,8'h00}), 8'd10,
             64'({8'h05,8'h00,8'h00,8'h00}), 8'd4};
    vt[7] = {160'({8'h88,8'h00,8'h02,8'h00}), 8'd4, 64'({8'h00,8'h00,8'h00,8'h00}), 8'd4};
    vt[8] = {160'({8'hEC,8'h00,8'h04,8'h00,8'hEC,8'h00,8'h05,8'h00,8'h77}), 8'd9, 64'({8'h77}), 8'd1};

    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset tx_o idle", {31'd0, tx_o}, 32'd1);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post-reset tx_o idle", {31'd0, tx_o}, 32'd1);

    for (int v = 0; v < 9; v++) begin
      send_pk(vt[v].din, int'(vt[v].nin));
      expect_pk($sformatf("vec%0d", v), vt[v].dexp, int'(vt[v].nexp));
    end

    // Echo latency from an idle transmitter.
    send_pk({8'hEC,8'h00,8'h05,8'h00}, 4);
    send_last_timed(8'h5A, lat);
    chk($sformatf("echo latency %0d<=16", lat), 32'(lat <= 16), 32'd1);
    expect_pk("echo timed", 64'h5A, 1);

    // Multiply result latency covers the final 32-cycle multiply.
    send_pk({8'h88,8'h00,8'h0C,8'h00,8'h03,8'h00,8'h00,8'h00,8'h07,8'h00,8'h00}, 11);
    send_last_timed(8'h00, lat);
    chk($sformatf("mul latency %0d<=48", lat), 32'(lat <= 48), 32'd1);
    expect_pk("mul timed", 64'({8'h15,8'h00,8'h00,8'h00}), 4);

    // Reset in the middle of an add payload.
    send_pk({8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h00}, 6);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      chk($sformatf("tx_o high in reset %0d", i), {31'd0, tx_o}, 32'd1);
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_pk({8'hEC,8'h00,8'h05,8'h00,8'h33}, 5);
    expect_pk("after reset", 64'h33, 1);

    // Reset while a byte is being transmitted cuts it immediately.
    send_pk({8'hEC,8'h00,8'h05,8'h00,8'h00}, 5);
    lat = 0;
    while (tx_o !== 1'b0 && lat < 200) begin @(negedge clk); lat++; end
    chk("tx start before cut", {31'd0, tx_o}, 32'd0);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1 chk("tx_o high at reset", {31'd0, tx_o}, 32'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    got.delete();
    send_pk({8'hEC,8'h00,8'h05,8'h00,8'h66}, 5);
    expect_pk("after cut", 64'h66, 1);

    run_random(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
